// File: rtl/fpu_resp_credit_buffer.sv
// Credit-gated response buffer between the FPU interconnect and the FPU wrapper.
// The FPU result path cannot be stalled. New requests are admitted only while
// inflight + count is below DEPTH, so every in-flight result has a FIFO slot.
// Buffered results are returned with a valid/ready handshake, in FPU return order.
module fpu_resp_credit_buffer #(
    parameter int ID_WIDTH        = 9,
    parameter int DATA_WIDTH      = 32,
    parameter int FLAGS_OUT_WIDTH = 5,
    parameter int DEPTH           = 4,
    parameter int CNT_WIDTH       = $clog2(DEPTH + 1)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       s_req_i,
    output logic                       s_gnt_o,
    output logic                       m_req_o,
    input  logic                       m_gnt_i,
    input  logic                       fpu_rvalid_i,
    input  logic [DATA_WIDTH-1:0]      fpu_rdata_i,
    input  logic [FLAGS_OUT_WIDTH-1:0] fpu_rflags_i,
    input  logic [ID_WIDTH-1:0]        fpu_rID_i,
    output logic                       s_rvalid_o,
    input  logic                       s_rready_i,
    output logic [DATA_WIDTH-1:0]      s_rdata_o,
    output logic [FLAGS_OUT_WIDTH-1:0] s_rflags_o,
    output logic [ID_WIDTH-1:0]        s_rID_o,
    output logic [CNT_WIDTH-1:0]       credits_o,
    output logic                       overflow_o
);

    localparam int PTR_WIDTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int ENTRY_WIDTH = DATA_WIDTH + FLAGS_OUT_WIDTH + ID_WIDTH;
    localparam logic [CNT_WIDTH-1:0] DEPTH_CNT = CNT_WIDTH'(DEPTH);
    localparam logic [PTR_WIDTH-1:0] LAST_PTR  = PTR_WIDTH'(DEPTH - 1);

    logic [CNT_WIDTH-1:0]   inflight;
    logic [CNT_WIDTH-1:0]   inflight_next;
    logic [CNT_WIDTH-1:0]   count;
    logic [CNT_WIDTH-1:0]   count_next;
    logic [PTR_WIDTH-1:0]   rd_ptr;
    logic [PTR_WIDTH-1:0]   wr_ptr;
    logic [ENTRY_WIDTH-1:0] mem [DEPTH];
    logic                   overflow;

    logic [CNT_WIDTH:0]     occupancy;
    logic                   has_credit;
    logic                   issue;
    logic                   push;
    logic                   pop;
    logic                   full;
    logic                   push_ok;

    // Request gating and handshake decode, from registered counters only
    always_comb begin
        occupancy  = {1'b0, inflight} + {1'b0, count};
        has_credit = occupancy < {1'b0, DEPTH_CNT};
        m_req_o    = s_req_i & has_credit;
        s_gnt_o    = m_req_o & m_gnt_i;
        issue      = s_gnt_o;
        push       = fpu_rvalid_i;
        full       = (count == DEPTH_CNT);
        pop        = (count != '0) & s_rready_i;
        // a full FIFO can still take a result when the head leaves this cycle
        push_ok    = push & (~full | pop);
    end

    // Next-state arithmetic for the in-flight and occupancy counters
    always_comb begin
        inflight_next = inflight;
        if (issue && !push) begin
            inflight_next = inflight + 1'b1;
        end else if (!issue && push && (inflight != '0)) begin
            // a spurious result with nothing outstanding leaves inflight at 0
            inflight_next = inflight - 1'b1;
        end

        count_next = count;
        if (push_ok && !pop) begin
            count_next = count + 1'b1;
        end else if (!push_ok && pop) begin
            count_next = count - 1'b1;
        end
    end

    // Counter, pointer and sticky overflow registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= '0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            inflight <= inflight_next;
            count    <= count_next;
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
            if (push_ok) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (push && !push_ok) begin
                overflow <= 1'b1;
            end
        end
    end

    // Response storage; cleared on reset so the head reads zero when idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push_ok) begin
            mem[wr_ptr] <= {fpu_rdata_i, fpu_rflags_i, fpu_rID_i};
        end
    end

    // Head-of-FIFO presentation and credit report
    always_comb begin
        {s_rdata_o, s_rflags_o, s_rID_o} = mem[rd_ptr];
        s_rvalid_o = (count != '0);
        credits_o  = DEPTH_CNT - inflight - count;
        overflow_o = overflow;
    end

`ifndef SYNTHESIS
    a_occupancy_bound : assert property (@(posedge clk) disable iff (!rst_n)
        occupancy <= {1'b0, DEPTH_CNT});
    a_req_needs_credit : assert property (@(posedge clk) disable iff (!rst_n)
        !(m_req_o && !has_credit));
`endif

endmodule

// File: doc/fpu_resp_credit_buffer.md
Name: fpu_resp_credit_buffer

Overview:
Sits between the FPU interconnect and the fpnew-based FPU wrapper, on both its request and response sides.
- The FPU response path has no backpressure: its output ready is tied high and rready is ignored.
- This block gates new requests with a credit counter so every in-flight operation is guaranteed a slot in a local response FIFO.
- The FIFO presents responses to the interconnect with a proper rvalid/rready handshake.
- Operands, opcode and flags bypass this block. Only the handshake is gated.

Parameters:
ID_WIDTH, 9, width of request/response tag
DATA_WIDTH, 32, response data width
FLAGS_OUT_WIDTH, 5, response status flag width
DEPTH, 4, response FIFO entries and total credits (legal range 1..16)
CNT_WIDTH, $clog2(DEPTH+1), width of counters and credits_o

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
s_req_i  input  1  request valid from interconnect
s_gnt_o  output  1  request accepted
m_req_o  output  1  request valid to FPU wrapper
m_gnt_i  input  1  FPU wrapper ready
fpu_rvalid_i  input  1  FPU result valid (cannot be stalled)
fpu_rdata_i  input  DATA_WIDTH  FPU result
fpu_rflags_i  input  FLAGS_OUT_WIDTH  FPU status flags
fpu_rID_i  input  ID_WIDTH  FPU result tag
s_rvalid_o  output  1  buffered response valid
s_rready_i  input  1  consumer ready
s_rdata_o  output  DATA_WIDTH  head-of-FIFO data
s_rflags_o  output  FLAGS_OUT_WIDTH  head-of-FIFO flags
s_rID_o  output  ID_WIDTH  head-of-FIFO tag
credits_o  output  CNT_WIDTH  DEPTH - inflight - count
overflow_o  output  1  sticky error: push while FIFO full

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock clk.
  - All of inflight, count, rd_ptr, wr_ptr and overflow_o reset to 0.
  - s_rvalid_o = 0, credits_o = DEPTH.
  - s_rdata_o, s_rflags_o and s_rID_o read 0 after reset (FIFO storage reset to 0).
  - Reset mid-operation discards all buffered and in-flight accounting. Results arriving afterwards for pre-reset requests are pushed as normal responses.
- State: registered counters inflight (issued, not yet returned) and count (FIFO occupancy), plus rd_ptr and wr_ptr wrapping modulo DEPTH.
- Invariant: inflight + count <= DEPTH.
- Request gating (combinational, zero latency):
  - has_credit = (inflight + count) < DEPTH, computed from registered values only.
  - m_req_o = s_req_i & has_credit.
  - s_gnt_o = m_req_o & m_gnt_i.
  - issue = s_gnt_o.
- Push: fpu_rvalid_i. Writes {rdata, rflags, rID} at wr_ptr and increments wr_ptr.
- Pop: s_rvalid_o & s_rready_i. Increments rd_ptr.
- s_rvalid_o = (count != 0). Outputs are driven from storage at rd_ptr, so latency from fpu_rvalid_i to s_rvalid_o is exactly 1 cycle. No bypass.
- Counter updates each cycle:
  - inflight_next = inflight + issue - push.
  - count_next = count + push - pop.
  - Simultaneous issue, push and pop are all legal in one cycle.
- Credit release: a pop in cycle t raises has_credit from cycle t+1. There is no same-cycle credit reuse.
- Ordering: responses leave in FPU return order. The block never reorders.
- Full FIFO (count == DEPTH): push with no pop in the same cycle drops the data and sets overflow_o = 1. overflow_o stays set until reset. Push with a simultaneous pop is legal.
- Push while inflight == 0 (spurious result): still stored if space exists; inflight saturates at 0.
- s_rdata_o, s_rflags_o and s_rID_o must hold stable while s_rvalid_o = 1 and s_rready_i = 0.
- Assertions:
  - inflight + count <= DEPTH.
  - m_req_o is never 1 when has_credit = 0.

Test Plan:
- Reset, then idle -> credits_o = 4, s_rvalid_o = 0, s_rdata_o = 0, overflow_o = 0.
- Streaming: s_rready_i = 1, m_gnt_i = 1, s_req_i held high, FPU returns each tag 2 cycles later -> s_gnt_o high every cycle, each response appears 1 cycle after fpu_rvalid_i, tags 0x01..0x08 leave in order.
- Backpressure: s_rready_i = 0, issue 4 requests, return all 4 -> credits_o = 0, m_req_o = 0 and s_gnt_o = 0 while s_req_i = 1. Head holds tag 0x01 with data 0x3F800000 stable.
- Credit release: from the full state, pulse s_rready_i for one cycle -> tag 0x01 popped, m_req_o = 1 exactly one cycle later, s_gnt_o = 1 when m_gnt_i = 1.
- Same-cycle events: count = 2, inflight = 1; in one cycle issue, push and pop together -> next cycle inflight = 1, count = 2, credits_o = 1.
- Error and reset:
  - Force fpu_rvalid_i with count = 4 and no pop -> overflow_o = 1 and stays set; FIFO contents unchanged.
  - Assert rst_n low mid-stream -> all outputs return to reset values asynchronously.
